// File: rtl/caxi4interconnect_resp_pkg.sv
// Shared constants, lock state type and ID field helper for the response arbiter.
package caxi4interconnect_resp_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Master index carried in the bits directly above the transaction ID.
  function automatic int unsigned master_field(input logic [63:0] full_id,
                                               input int unsigned id_width,
                                               input int unsigned master_width);
    logic [63:0] mask;
    mask = (64'd1 << master_width) - 64'd1;
    return 32'((full_id >> id_width) & mask);
  endfunction

endpackage

// File: rtl/caxi4interconnect_resp_master_port.sv
// Per-master response arbiter, slave mux and optional one-entry output register.
module caxi4interconnect_resp_master_port
  import caxi4interconnect_resp_pkg::*;
#(
  parameter int unsigned NUM_SLAVES       = 2,
  parameter int unsigned NUM_SLAVES_WIDTH = 1,
  parameter int unsigned ID_WIDTH         = 1,
  parameter int unsigned FULL_ID_WIDTH    = 2,
  parameter int unsigned USER_WIDTH       = 1,
  parameter int unsigned ARB_MODE         = ARB_RR,
  parameter int unsigned OUT_REG          = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SLAVES-1:0]               req,
  input  logic [NUM_SLAVES*FULL_ID_WIDTH-1:0] slave_id,
  input  logic [NUM_SLAVES*2-1:0]             slave_resp,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0]    slave_user,
  input  logic                                master_ready,
  output logic [NUM_SLAVES-1:0]               slave_ready,
  output logic                                master_valid,
  output logic [ID_WIDTH-1:0]                 master_id,
  output logic [1:0]                          master_resp,
  output logic [USER_WIDTH-1:0]               master_user,
  output logic [FULL_ID_WIDTH-1:0]            curr_id,
  output logic                                open_dec
);

  localparam int unsigned IDX_W = NUM_SLAVES_WIDTH;

  lock_state_e              state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]         lo_idx, hi_idx, winner, sel;
  logic                     hi_found, any_req, sel_valid, load;
  logic                     full_q, full_d;
  logic [FULL_ID_WIDTH-1:0] sel_id, id_q, id_d;
  logic [1:0]               sel_resp, resp_q, resp_d;
  logic [USER_WIDTH-1:0]    sel_user, user_q, user_d;

  // Rotating priority: first requester at or above the pointer, else the lowest requester
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = IDX_W'(i);
      if (req[i] && (i >= int'(ptr_q))) begin
        hi_idx   = IDX_W'(i);
        hi_found = 1'b1;
      end
    end
    winner  = hi_found ? hi_idx : lo_idx;
    any_req = |req;
  end

  // Held grant overrides the search while a combinational response is stalled
  always_comb begin
    sel       = (OUT_REG == 0 && state_q == ST_LOCKED) ? lock_idx_q : winner;
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_resp  = '0;
    sel_user  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel == IDX_W'(i)) begin
        sel_valid = req[i];
        sel_id    = slave_id[i*FULL_ID_WIDTH +: FULL_ID_WIDTH];
        sel_resp  = slave_resp[i*2 +: 2];
        sel_user  = slave_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Next-state, pointer advance and master-side outputs
  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx_q;
    ptr_d        = ptr_q;
    full_d       = full_q;
    id_d         = id_q;
    resp_d       = resp_q;
    user_d       = user_q;
    load         = 1'b0;
    slave_ready  = '0;
    master_valid = 1'b0;
    master_id    = '0;
    master_resp  = '0;
    master_user  = '0;
    curr_id      = '0;
    if (OUT_REG == 0) begin
      master_valid = sel_valid && !rst;
      master_id    = sel_id[ID_WIDTH-1:0];
      master_resp  = sel_resp;
      master_user  = sel_user;
      curr_id      = sel_id;
      for (int i = 0; i < int'(NUM_SLAVES); i++)
        slave_ready[i] = master_valid && master_ready && (sel == IDX_W'(i));
      if (master_valid && !master_ready) begin
        state_d    = ST_LOCKED;
        lock_idx_d = sel;
      end else begin
        state_d = ST_OPEN;
      end
      if (master_valid && master_ready && ARB_MODE == ARB_RR)
        ptr_d = (int'(sel) == int'(NUM_SLAVES) - 1) ? '0 : sel + IDX_W'(1);
    end else begin
      master_valid = full_q && !rst;
      master_id    = id_q[ID_WIDTH-1:0];
      master_resp  = resp_q;
      master_user  = user_q;
      curr_id      = id_q;
      load         = any_req && (!full_q || master_ready) && !rst;
      for (int i = 0; i < int'(NUM_SLAVES); i++)
        slave_ready[i] = load && (winner == IDX_W'(i));
      if (load) begin
        full_d = 1'b1;
        id_d   = sel_id;
        resp_d = sel_resp;
        user_d = sel_user;
        if (ARB_MODE == ARB_RR)
          ptr_d = (int'(winner) == int'(NUM_SLAVES) - 1) ? '0 : winner + IDX_W'(1);
      end else if (master_ready) begin
        full_d = 1'b0;
      end
    end
    open_dec = master_valid && master_ready;
  end

  // Lock, pointer and output-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OPEN;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      full_q     <= 1'b0;
      id_q       <= '0;
      resp_q     <= '0;
      user_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      full_q     <= full_d;
      id_q       <= id_d;
      resp_q     <= resp_d;
      user_q     <= user_d;
    end
  end

endmodule

// File: rtl/caxi4interconnect_resp_arb_ctrl.sv
// Routes slave responses back to their originating masters, one arbiter per master.
module caxi4interconnect_resp_arb_ctrl
  import caxi4interconnect_resp_pkg::*;
#(
  parameter int unsigned NUM_MASTERS          = 2,
  parameter int unsigned NUM_MASTERS_WIDTH    = 1,
  parameter int unsigned NUM_SLAVES           = 2,
  parameter int unsigned NUM_SLAVES_WIDTH     = 1,
  parameter int unsigned ID_WIDTH             = 1,
  parameter int unsigned USER_WIDTH           = 1,
  parameter int unsigned SUPPORT_USER_SIGNALS = 0,
  parameter logic [NUM_MASTERS*NUM_SLAVES-1:0] MASTER_CONNECTIVITY = '1,
  parameter int unsigned ARB_MODE             = ARB_RR,
  parameter int unsigned OUT_REG              = 0
) (
  input  logic                                                sysClk,
  input  logic                                                sysReset,
  input  logic [NUM_SLAVES*(NUM_MASTERS_WIDTH+ID_WIDTH)-1:0]  SLAVE_ID,
  input  logic [NUM_SLAVES*2-1:0]                             SLAVE_RESP,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0]                    SLAVE_USER,
  input  logic [NUM_SLAVES-1:0]                               SLAVE_VALID,
  output logic [NUM_SLAVES-1:0]                               SLAVE_READY,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]                     MASTER_ID,
  output logic [NUM_MASTERS*2-1:0]                            MASTER_RESP,
  output logic [NUM_MASTERS*USER_WIDTH-1:0]                   MASTER_USER,
  output logic [NUM_MASTERS-1:0]                              MASTER_VALID,
  input  logic [NUM_MASTERS-1:0]                              MASTER_READY,
  output logic [NUM_MASTERS*(NUM_MASTERS_WIDTH+ID_WIDTH)-1:0] currDataTransID,
  output logic [NUM_MASTERS-1:0]                              openTransDec,
  output logic                                                unroutedResp
);

  localparam int unsigned FIW = NUM_MASTERS_WIDTH + ID_WIDTH;

  int unsigned           target [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] routed, unrouted;
  logic [NUM_SLAVES-1:0] req_m   [NUM_MASTERS];
  logic [NUM_SLAVES-1:0] ready_m [NUM_MASTERS];
  logic [USER_WIDTH-1:0] user_m  [NUM_MASTERS];

  // Decode each slave's target master and build per-master request vectors
  always_comb begin
    routed = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++)
      target[s] = master_field(64'(SLAVE_ID[s*FIW +: FIW]), ID_WIDTH, NUM_MASTERS_WIDTH);
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      req_m[m] = '0;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (target[s] == m && MASTER_CONNECTIVITY[m*NUM_SLAVES + s]) begin
          routed[s]   = 1'b1;
          req_m[m][s] = SLAVE_VALID[s];
        end
      end
    end
    unrouted = SLAVE_VALID & ~routed;
  end

  // Merge grant readies and sink responses that have nowhere to go
  always_comb begin
    SLAVE_READY = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++)
      SLAVE_READY |= ready_m[m];
    if (!sysReset) SLAVE_READY |= unrouted;
    unroutedResp = (|unrouted) && !sysReset;
  end

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_port
    caxi4interconnect_resp_master_port #(
      .NUM_SLAVES      (NUM_SLAVES),
      .NUM_SLAVES_WIDTH(NUM_SLAVES_WIDTH),
      .ID_WIDTH        (ID_WIDTH),
      .FULL_ID_WIDTH   (FIW),
      .USER_WIDTH      (USER_WIDTH),
      .ARB_MODE        (ARB_MODE),
      .OUT_REG         (OUT_REG)
    ) u_port (
      .clk         (sysClk),
      .rst         (sysReset),
      .req         (req_m[m]),
      .slave_id    (SLAVE_ID),
      .slave_resp  (SLAVE_RESP),
      .slave_user  (SLAVE_USER),
      .master_ready(MASTER_READY[m]),
      .slave_ready (ready_m[m]),
      .master_valid(MASTER_VALID[m]),
      .master_id   (MASTER_ID[m*ID_WIDTH +: ID_WIDTH]),
      .master_resp (MASTER_RESP[m*2 +: 2]),
      .master_user (user_m[m]),
      .curr_id     (currDataTransID[m*FIW +: FIW]),
      .open_dec    (openTransDec[m])
    );
    assign MASTER_USER[m*USER_WIDTH +: USER_WIDTH] = (SUPPORT_USER_SIGNALS != 0) ? user_m[m] : '0;
  end

endmodule

// File: tb/tb_caxi4interconnect_resp_arb_ctrl.sv
// Directed bench: RR 2x2 combinational, RR 2x2 registered with sparse connectivity, fixed-priority 2x4.
module tb_caxi4interconnect_resp_arb_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests;
  int   fails;

  always #5 clk = ~clk;

  logic [3:0] a_sid, a_sresp, a_cur, a_mresp;
  logic [1:0] a_suser, a_sval, a_srdy, a_mid, a_muser, a_mval, a_mrdy, a_otd;
  logic       a_unr;
  logic [3:0] b_sid, b_sresp, b_cur, b_mresp;
  logic [1:0] b_suser, b_sval, b_srdy, b_mid, b_muser, b_mval, b_mrdy, b_otd;
  logic       b_unr;
  logic [7:0] c_sid, c_sresp;
  logic [3:0] c_suser, c_sval, c_srdy, c_cur, c_mresp;
  logic [1:0] c_mid, c_muser, c_mval, c_mrdy, c_otd;
  logic       c_unr;

  caxi4interconnect_resp_arb_ctrl dut_a (
    .sysClk(clk), .sysReset(rst),
    .SLAVE_ID(a_sid), .SLAVE_RESP(a_sresp), .SLAVE_USER(a_suser), .SLAVE_VALID(a_sval),
    .SLAVE_READY(a_srdy), .MASTER_ID(a_mid), .MASTER_RESP(a_mresp), .MASTER_USER(a_muser),
    .MASTER_VALID(a_mval), .MASTER_READY(a_mrdy), .currDataTransID(a_cur),
    .openTransDec(a_otd), .unroutedResp(a_unr)
  );

  caxi4interconnect_resp_arb_ctrl #(
    .SUPPORT_USER_SIGNALS(1), .MASTER_CONNECTIVITY(4'b1101), .OUT_REG(1)
  ) dut_b (
    .sysClk(clk), .sysReset(rst),
    .SLAVE_ID(b_sid), .SLAVE_RESP(b_sresp), .SLAVE_USER(b_suser), .SLAVE_VALID(b_sval),
    .SLAVE_READY(b_srdy), .MASTER_ID(b_mid), .MASTER_RESP(b_mresp), .MASTER_USER(b_muser),
    .MASTER_VALID(b_mval), .MASTER_READY(b_mrdy), .currDataTransID(b_cur),
    .openTransDec(b_otd), .unroutedResp(b_unr)
  );

  caxi4interconnect_resp_arb_ctrl #(
    .NUM_SLAVES(4), .NUM_SLAVES_WIDTH(2), .ARB_MODE(1)
  ) dut_c (
    .sysClk(clk), .sysReset(rst),
    .SLAVE_ID(c_sid), .SLAVE_RESP(c_sresp), .SLAVE_USER(c_suser), .SLAVE_VALID(c_sval),
    .SLAVE_READY(c_srdy), .MASTER_ID(c_mid), .MASTER_RESP(c_mresp), .MASTER_USER(c_muser),
    .MASTER_VALID(c_mval), .MASTER_READY(c_mrdy), .currDataTransID(c_cur),
    .openTransDec(c_otd), .unroutedResp(c_unr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    a_sid = '0; a_sresp = '0; a_suser = 2'b11; a_sval = 2'b01; a_mrdy = 2'b11;
    b_sid = 4'b0100; b_sresp = '0; b_suser = '0; b_sval = 2'b10; b_mrdy = '0;
    c_sid = '0; c_sresp = '0; c_suser = '0; c_sval = '0; c_mrdy = '0;

    // Reset holds every handshake output low even with requests pending
    tick(); tick(); #1;
    chk("rst_a_mval", 64'(a_mval), 64'h0);
    chk("rst_a_srdy", 64'(a_srdy), 64'h0);
    chk("rst_a_otd", 64'(a_otd), 64'h0);
    chk("rst_b_srdy", 64'(b_srdy), 64'h0);
    chk("rst_b_unr", 64'(b_unr), 64'h0);

    // Round robin between two slaves targeting master 0, first grant right after reset
    b_sval = '0;
    a_sid = 4'b0100; a_sresp = 4'b1001; a_sval = 2'b11;
    rst = 1'b0; #1;
    chk("usr_forced_zero", 64'(a_muser), 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_srdy", 64'(a_srdy), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_mid", 64'(a_mid[0]), (i % 2 == 0) ? 64'h0 : 64'h1);
      chk("rr_resp", 64'(a_mresp[1:0]), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_cur", 64'(a_cur[1:0]), (i % 2 == 0) ? 64'h0 : 64'h1);
      chk("rr_mval", 64'(a_mval), 64'h1);
      chk("rr_otd", 64'(a_otd), 64'h1);
      tick();
    end

    // Backpressure on master 0: slave 1 stays granted while slave 0 waits
    a_sval = 2'b10; a_mrdy = 2'b10; #1;
    chk("lock_first_mval", 64'(a_mval[0]), 64'h1);
    chk("lock_first_mid", 64'(a_mid[0]), 64'h1);
    chk("lock_first_otd", 64'(a_otd), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      a_sval = 2'b11; #1;
      chk("lock_mid", 64'(a_mid[0]), 64'h1);
      chk("lock_resp", 64'(a_mresp[1:0]), 64'h2);
      chk("lock_srdy", 64'(a_srdy), 64'h0);
      chk("lock_mval", 64'(a_mval[0]), 64'h1);
    end
    tick();
    a_mrdy = 2'b11; #1;
    chk("lock_release_srdy", 64'(a_srdy), 64'h2);
    chk("lock_release_otd", 64'(a_otd), 64'h1);
    chk("lock_release_mid", 64'(a_mid[0]), 64'h1);
    tick();
    a_sval = 2'b01; #1;
    chk("after_lock_srdy", 64'(a_srdy), 64'h1);
    chk("after_lock_mid", 64'(a_mid[0]), 64'h0);

    // Parallel delivery to both masters in the same cycle
    tick();
    a_sid = 4'b1100; a_sval = 2'b11; #1;
    chk("par_a_mval", 64'(a_mval), 64'h3);
    chk("par_a_srdy", 64'(a_srdy), 64'h3);
    chk("par_a_mid", 64'(a_mid), 64'h2);
    chk("par_a_cur", 64'(a_cur), 64'hC);
    chk("par_a_otd", 64'(a_otd), 64'h3);
    tick();
    a_sval = '0;

    // Registered stage: capture this cycle, present next cycle
    b_sid = 4'b1100; b_sval = 2'b11; b_mrdy = 2'b11; b_suser = 2'b01; #1;
    chk("reg_cap_srdy", 64'(b_srdy), 64'h3);
    chk("reg_cap_mval", 64'(b_mval), 64'h0);
    tick();
    b_sval = '0; #1;
    chk("reg_out_mval", 64'(b_mval), 64'h3);
    chk("reg_out_mid", 64'(b_mid), 64'h2);
    chk("reg_out_cur", 64'(b_cur), 64'hC);
    chk("reg_out_otd", 64'(b_otd), 64'h3);
    chk("reg_out_user", 64'(b_muser), 64'h1);
    tick(); #1;
    chk("reg_drained_mval", 64'(b_mval), 64'h0);

    // Unconnected slave 1 -> master 0 is absorbed and flagged
    tick();
    b_sid = 4'b0100; b_sval = 2'b10; #1;
    chk("unr_srdy", 64'(b_srdy), 64'h2);
    chk("unr_pulse", 64'(b_unr), 64'h1);
    chk("unr_mval", 64'(b_mval), 64'h0);
    tick();
    b_sval = '0; #1;
    chk("unr_pulse_end", 64'(b_unr), 64'h0);
    chk("unr_not_fwd", 64'(b_mval), 64'h0);

    // Hold a registered response on master 1, then reset mid-transfer
    tick();
    b_sid = 4'b0010; b_sresp = 4'b0011; b_sval = 2'b01; b_mrdy = 2'b01; #1;
    chk("hold_cap_srdy", 64'(b_srdy), 64'h1);
    tick();
    b_sval = '0; #1;
    chk("hold_mval", 64'(b_mval), 64'h2);
    chk("hold_resp", 64'(b_mresp[3:2]), 64'h3);
    chk("hold_otd", 64'(b_otd), 64'h0);
    tick(); #1;
    chk("hold_mval_stable", 64'(b_mval), 64'h2);
    chk("hold_resp_stable", 64'(b_mresp[3:2]), 64'h3);
    tick();
    rst = 1'b1; #1;
    chk("rst_mid_mval", 64'(b_mval), 64'h0);
    tick();
    rst = 1'b0;
    b_sid = 4'b1110; b_sval = 2'b11; b_mrdy = 2'b11; #1;
    chk("post_rst_mval", 64'(b_mval), 64'h0);
    chk("post_rst_ptr0", 64'(b_srdy), 64'h1);
    tick(); #1;
    chk("post_rst_out_mval", 64'(b_mval), 64'h2);
    chk("post_rst_out_mid", 64'(b_mid[1]), 64'h0);
    chk("post_rst_rr_next", 64'(b_srdy), 64'h2);
    tick();
    b_sval = '0; #1;
    chk("post_rst_out2_mid", 64'(b_mid[1]), 64'h1);
    chk("post_rst_out2_mval", 64'(b_mval), 64'h2);

    // Fixed priority: slave 0 wins every cycle, then the lowest remaining requester
    tick();
    c_sid = 8'b11101110; c_sval = 4'b1111; c_mrdy = 2'b10; #1;
    for (int i = 0; i < 3; i++) begin
      chk("fix_s0_srdy", 64'(c_srdy), 64'h1);
      chk("fix_s0_mval", 64'(c_mval), 64'h2);
      chk("fix_s0_mid", 64'(c_mid[1]), 64'h0);
      tick(); #1;
    end
    c_sval = 4'b1110; #1;
    chk("fix_s1_srdy", 64'(c_srdy), 64'h2);
    chk("fix_s1_mid", 64'(c_mid[1]), 64'h1);
    tick(); #1;
    chk("fix_s1_again", 64'(c_srdy), 64'h2);
    tick();
    c_sval = 4'b1100; #1;
    chk("fix_s2_srdy", 64'(c_srdy), 64'h4);
    chk("fix_unr", 64'(c_unr), 64'h0);
    tick();
    c_sval = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
